// File: rtl/delay_sram_arbiter.sv
// rtl/delay_sram_arbiter.sv - round-robin arbiter sharing the delay-line SRAM with bank ownership checks
module delay_sram_arbiter #(
    parameter int n_requesters   = 4,
    parameter int data_width     = 16,
    parameter int n_sram_banks   = 64,
    parameter int sram_bank_size = 1024,
    localparam int bank_w        = $clog2(n_sram_banks),
    localparam int offset_w      = $clog2(sram_bank_size),
    localparam int id_w          = $clog2(n_requesters)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [n_requesters-1:0]             req,
    input  logic [n_requesters-1:0]             req_write,
    input  logic [n_requesters*bank_w-1:0]      req_bank,
    input  logic [n_requesters*offset_w-1:0]    req_offset,
    input  logic [n_requesters*data_width-1:0]  req_wdata,
    output logic [n_requesters-1:0]             ack,
    output logic [n_requesters-1:0]             rvalid,
    output logic [data_width-1:0]               rdata,
    output logic                                sram_en,
    output logic                                sram_we,
    output logic [bank_w+offset_w-1:0]          sram_addr,
    output logic [data_width-1:0]               sram_wdata,
    input  logic [data_width-1:0]               sram_rdata,
    input  logic                                alloc_write,
    input  logic [bank_w-1:0]                   alloc_bank,
    input  logic [id_w-1:0]                     alloc_owner,
    input  logic                                alloc_free,
    output logic                                fault,
    output logic [id_w-1:0]                     fault_requester,
    input  logic                                clear_fault
);

    // Round-robin pointer and bank ownership table
    logic [id_w-1:0]         rr_ptr;
    logic [n_sram_banks-1:0] tbl_valid;
    logic [id_w-1:0]         tbl_owner [n_sram_banks];

    // Read return pipeline: stage 1 is the SRAM command cycle, stage 2 the SRAM data cycle
    logic            rd1_valid, rd2_valid;
    logic [id_w-1:0] rd1_id, rd2_id;
    logic            rd1_legal, rd2_legal;

    logic [n_requesters-1:0] eligible;
    logic                    grant_valid;
    logic [id_w-1:0]         grant_idx;
    logic [id_w:0]           cand;

    logic [bank_w-1:0]     sel_bank;
    logic [offset_w-1:0]   sel_offset;
    logic [data_width-1:0] sel_wdata;
    logic                  sel_write;
    logic                  legal;
    logic                  violation;

    // Pick the first eligible requester at or after rr_ptr; the one acked last cycle is masked
    always_comb begin
        eligible    = req & ~ack;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < n_requesters; i++) begin
            cand = {1'b0, rr_ptr} + (id_w+1)'(i);
            if (cand >= (id_w+1)'(n_requesters))
                cand = cand - (id_w+1)'(n_requesters);
            if (!grant_valid && eligible[cand[id_w-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[id_w-1:0];
            end
        end
    end

    // Select the granted requester's fields and check ownership against the pre-update table
    always_comb begin
        sel_bank   = req_bank[int'(grant_idx)*bank_w +: bank_w];
        sel_offset = req_offset[int'(grant_idx)*offset_w +: offset_w];
        sel_wdata  = req_wdata[int'(grant_idx)*data_width +: data_width];
        sel_write  = req_write[grant_idx];
        legal      = tbl_valid[sel_bank] && (tbl_owner[sel_bank] == grant_idx);
        violation  = grant_valid && !legal;
    end

    // Register the grant: ack pulse, pointer advance and SRAM command for legal accesses
    always_ff @(posedge clk) begin
        if (reset) begin
            ack        <= '0;
            rr_ptr     <= '0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            ack     <= '0;
            sram_en <= 1'b0;
            sram_we <= 1'b0;
            if (grant_valid) begin
                ack[grant_idx] <= 1'b1;
                rr_ptr <= (grant_idx == id_w'(n_requesters - 1)) ? '0 : grant_idx + 1'b1;
                if (legal) begin
                    sram_en    <= 1'b1;
                    sram_we    <= sel_write;
                    sram_addr  <= {sel_bank, sel_offset};
                    sram_wdata <= sel_wdata;
                end
            end
        end
    end

    // Carry granted reads through the SRAM latency; blocked reads return zero
    always_ff @(posedge clk) begin
        if (reset) begin
            rd1_valid <= 1'b0;
            rd1_id    <= '0;
            rd1_legal <= 1'b0;
            rd2_valid <= 1'b0;
            rd2_id    <= '0;
            rd2_legal <= 1'b0;
            rvalid    <= '0;
            rdata     <= '0;
        end else begin
            rd1_valid <= grant_valid && !sel_write;
            rd1_id    <= grant_idx;
            rd1_legal <= legal;
            rd2_valid <= rd1_valid;
            rd2_id    <= rd1_id;
            rd2_legal <= rd1_legal;
            rvalid    <= '0;
            if (rd2_valid) begin
                rvalid[rd2_id] <= 1'b1;
                rdata          <= rd2_legal ? sram_rdata : '0;
            end
        end
    end

    // Sticky fault flag; the first offender is kept until cleared, a new fault beats a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            fault           <= 1'b0;
            fault_requester <= '0;
        end else if (violation) begin
            fault <= 1'b1;
            if (!fault || clear_fault)
                fault_requester <= grant_idx;
        end else if (clear_fault) begin
            fault           <= 1'b0;
            fault_requester <= '0;
        end
    end

    // Ownership valid bits, cleared on reset and updated by the control unit
    always_ff @(posedge clk) begin
        if (reset)
            tbl_valid <= '0;
        else if (alloc_write)
            tbl_valid[alloc_bank] <= !alloc_free;
    end

    // Owner ids only matter while the valid bit is set, so they need no reset
    always_ff @(posedge clk) begin
        if (!reset && alloc_write && !alloc_free)
            tbl_owner[alloc_bank] <= alloc_owner;
    end

endmodule

// File: doc/delay_sram_arbiter.md
# delay_sram_arbiter

Shares the single-port delay-line SRAM between the delay units of both DSP pipelines. Each requester issues a read or write to a (bank, offset) location; the arbiter grants one access per cycle round-robin, checks that the requester owns the addressed bank, drives the SRAM, and returns read data with fixed latency. The bank ownership table is written by the control unit when delay buffers are allocated or freed.

## Interface
- n_requesters, 4, number of delay-unit ports (≥2)
- data_width, 16, sample/word width
- n_sram_banks, 64, number of banks
- sram_bank_size, 1024, words per bank; BW = $clog2(n_sram_banks), OW = $clog2(sram_bank_size), RW = $clog2(n_requesters)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  n_requesters  access request per requester, held until ack
- req_write  in  n_requesters  1 = write, 0 = read
- req_bank  in  n_requesters*BW  flattened bank index, requester i at [i*BW +: BW]
- req_offset  in  n_requesters*OW  flattened word offset
- req_wdata  in  n_requesters*data_width  flattened write data
- ack  out  n_requesters  one-cycle grant pulse
- rvalid  out  n_requesters  one-cycle read-data-valid pulse
- rdata  out  data_width  read data, shared, qualified by rvalid
- sram_en  out  1  SRAM access enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  BW+OW  {bank, offset}
- sram_wdata  out  data_width  SRAM write data
- sram_rdata  in  data_width  SRAM read data, valid the cycle after sram_en with sram_we=0
- alloc_write  in  1  ownership table update strobe
- alloc_bank  in  BW  bank to update
- alloc_owner  in  RW  new owner
- alloc_free  in  1  1 = mark bank unowned, owner ignored
- fault  out  1  sticky ownership violation flag
- fault_requester  out  RW  requester that caused the first fault
- clear_fault  in  1  clears fault and fault_requester

## Operation
- Arbitration: eligible = req & ~last_grant_mask (the requester acked in the previous cycle is masked for one cycle). Grant the first eligible index at or after rr_ptr, wrapping; then rr_ptr <= granted+1 mod n_requesters. No eligible request: no grant, rr_ptr unchanged.
- Grant registers into cycle+1: ack[g]=1, and either a legal SRAM access or a blocked access.
- Ownership table: n_sram_banks entries of {valid, owner}. Access legal iff entry valid and owner == g. Check uses the table value before any same-cycle alloc_write.
- Legal: sram_en=1, sram_we=req_write[g], sram_addr={bank,offset}, sram_wdata=req_wdata[g].
- Illegal: sram_en=0; ack still pulses; for reads rvalid[g] still pulses with rdata=0; if fault=0 then fault<=1, fault_requester<=g. Later faults do not overwrite fault_requester.
- clear_fault and a new fault in the same cycle: new fault wins (fault=1, new requester captured).
- alloc_write: entry <= alloc_free ? {0,x} : {1,alloc_owner}; takes effect for grants evaluated next cycle onward.
- Writes produce no rvalid.

## Timing
- Cycle 0: req[i] high (sampled at edge 1). Cycle 1: ack[i], SRAM command. Cycle 2: sram_rdata valid. Cycle 3: rdata/rvalid[i] (registered). Read latency req→rvalid = 3 cycles with no contention.
- Requester holds req and fields stable through its ack cycle and drops req (or presents a new request) the following cycle; masking guarantees no double grant of a held request.
- Sustained throughput: one access per cycle across requesters; any single requester at most one grant per 2 cycles.
- Worst-case wait with all requesting: n_requesters−1 grants.
- Reset values: ack=0, rvalid=0, rdata=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, fault=0, fault_requester=0, rr_ptr=0, mask=0, all table entries invalid.
- Reset mid-operation: in-flight read is dropped (no rvalid after reset), table cleared, everything returns to reset values the cycle after reset is sampled.

## Test plan
- Reset, alloc bank 3→owner 1; requester 1 writes 0x1234 to bank 3 offset 5, then reads it → ack cycle 1, sram_addr=0xC05 (BW=6,OW=10), rvalid[1] 3 cycles after read req with rdata=0x1234, fault=0.
- All 4 requesters hold req continuously, each owning its bank → acks in order 0,1,2,3,0,… one per cycle, no requester acked in consecutive cycles.
- Requester 2 reads bank 7 (unowned) → ack[2], sram_en=0, rvalid[2] with rdata=0, fault=1, fault_requester=2; then requester 0 faults → fault_requester stays 2; clear_fault → fault=0.
- alloc_write freeing bank 3 in the same cycle requester 1's access to bank 3 is granted → access legal (old table), next access to bank 3 faults.
- Assert reset one cycle after a read's ack → no rvalid ever appears, all outputs 0, rr_ptr 0, previously owned banks now fault.
- Only requester 3 requesting, req held → ack[3] every other cycle, rr_ptr wraps to 0.
